// File: rtl/round_sequencer.sv
// round_sequencer: ASCON permutation round sequencer.
// Steps the round index from the mode's start index up to MAX_ROUNDS-1.
// Supports a start handshake, stall, and abort, and produces first/last
// round flags plus a one-cycle completion pulse.
module round_sequencer #(
  parameter int MAX_ROUNDS = 12,
  parameter int ROUND_W    = 4,
  parameter int ROUNDS_A   = 12,
  parameter int ROUNDS_B   = 6
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               en_i,
  input  logic               abort_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               busy_o,
  output logic               first_o,
  output logic               last_o,
  output logic               done_o
);

  // Reject parameter sets that would let the index overflow or start out of range.
  if (MAX_ROUNDS < 1 || (2 ** ROUND_W) < MAX_ROUNDS) begin : g_bad_max
    $error("round_sequencer: MAX_ROUNDS does not fit in ROUND_W");
  end
  if (ROUNDS_A < 1 || ROUNDS_A > MAX_ROUNDS) begin : g_bad_a
    $error("round_sequencer: ROUNDS_A out of range");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > MAX_ROUNDS) begin : g_bad_b
    $error("round_sequencer: ROUNDS_B out of range");
  end

  localparam logic [ROUND_W-1:0] START_A = ROUND_W'(MAX_ROUNDS - ROUNDS_A);
  localparam logic [ROUND_W-1:0] START_B = ROUND_W'(MAX_ROUNDS - ROUNDS_B);
  localparam logic [ROUND_W-1:0] LAST    = ROUND_W'(MAX_ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_n;
  logic [ROUND_W-1:0] round, round_n;
  logic               done, done_n;
  logic               mode, mode_n;

  // State register; the captured mode is only needed to decode first_o.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state <= IDLE;
      round <= '0;
      done  <= 1'b0;
      mode  <= 1'b0;
    end else begin
      state <= state_n;
      round <= round_n;
      done  <= done_n;
      mode  <= mode_n;
    end
  end

  // Next-state logic; abort wins over start, advance and completion.
  always_comb begin
    state_n = state;
    round_n = round;
    done_n  = 1'b0;
    mode_n  = mode;
    if (abort_i) begin
      state_n = IDLE;
      round_n = '0;
    end else begin
      case (state)
        IDLE: begin
          round_n = '0;
          if (start_i) begin
            state_n = RUN;
            mode_n  = mode_i;
            round_n = mode_i ? START_B : START_A;
          end
        end
        RUN: begin
          if (en_i) begin
            if (round == LAST) begin
              state_n = IDLE;
              round_n = '0;
              done_n  = 1'b1;
            end else begin
              round_n = round + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          round_n = '0;
        end
      endcase
    end
  end

  assign round_o = round;
  assign busy_o  = (state == RUN);
  assign first_o = busy_o && (round == (mode ? START_B : START_A));
  assign last_o  = busy_o && (round == LAST);
  assign done_o  = done;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a vector table for the default
// instance plus a hand sequence for a 16-round single-round-mode instance.
module tb_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, start, mode, en, abort;
  logic [3:0] round_a, round_b;
  logic       busy_a, first_a, last_a, done_a;
  logic       busy_b, first_b, last_b, done_b;

  round_sequencer dut_a (
    .clock_i(clk), .resetb_i(rstb), .start_i(start), .mode_i(mode),
    .en_i(en), .abort_i(abort), .round_o(round_a), .busy_o(busy_a),
    .first_o(first_a), .last_o(last_a), .done_o(done_a)
  );

  round_sequencer #(.MAX_ROUNDS(16), .ROUND_W(4), .ROUNDS_A(12), .ROUNDS_B(1)) dut_b (
    .clock_i(clk), .resetb_i(rstb), .start_i(start), .mode_i(mode),
    .en_i(en), .abort_i(abort), .round_o(round_b), .busy_o(busy_b),
    .first_o(first_b), .last_o(last_b), .done_o(done_b)
  );

  typedef struct {
    bit       rstb, start, mode, en, abort;
    bit [3:0] round;
    bit       busy, first, last, done;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input bit rb, input bit st, input bit md, input bit e,
                     input bit ab, input int r, input bit b, input bit f,
                     input bit l, input bit d);
    vec_t v;
    v.rstb = rb; v.start = st; v.mode = md; v.en = e; v.abort = ab;
    v.round = 4'(r); v.busy = b; v.first = f; v.last = l; v.done = d;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rb, input bit st, input bit md, input bit e, input bit ab);
    rstb = rb; start = st; mode = md; en = e; abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; mode = 1'b0; en = 1'b0; abort = 1'b0;

    // rstb start mode en abort | round busy first last done
    add(0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0,0);
    // mode A full run: rounds 0..11, done in the 13th cycle
    add(1,1,0,1,0, 0,1,1,0,0);
    for (int r = 1; r <= 11; r++) add(1,0,0,1,0, r,1,0,(r == 11),0);
    add(1,0,0,1,0, 0,0,0,0,1);
    // back-to-back mode B start while done is high; mid-run start ignored
    add(1,1,1,1,0, 6,1,1,0,0);
    add(1,0,0,1,0, 7,1,0,0,0);
    add(1,1,0,1,0, 8,1,0,0,0);
    add(1,1,1,1,0, 9,1,0,0,0);
    add(1,0,0,1,0, 10,1,0,0,0);
    add(1,0,0,1,0, 11,1,0,1,0);
    add(1,0,0,1,0, 0,0,0,0,1);
    add(1,0,0,1,0, 0,0,0,0,0);
    // start and abort together in IDLE
    add(1,1,0,1,1, 0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0,0);
    // mode A with two-cycle stalls at rounds 3 and 11
    add(1,1,0,1,0, 0,1,1,0,0);
    for (int r = 1; r <= 3; r++) add(1,0,0,1,0, r,1,0,0,0);
    add(1,0,0,0,0, 3,1,0,0,0);
    add(1,0,0,0,0, 3,1,0,0,0);
    for (int r = 4; r <= 11; r++) add(1,0,0,1,0, r,1,0,(r == 11),0);
    add(1,0,0,0,0, 11,1,0,1,0);
    add(1,0,0,0,0, 11,1,0,1,0);
    add(1,0,0,1,0, 0,0,0,0,1);
    // abort at round 8 with en high
    add(1,1,0,1,0, 0,1,1,0,0);
    for (int r = 1; r <= 8; r++) add(1,0,0,1,0, r,1,0,0,0);
    add(1,0,0,1,1, 0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0,0);
    // abort on the final round suppresses done
    add(1,1,1,1,0, 6,1,1,0,0);
    for (int r = 7; r <= 11; r++) add(1,0,0,1,0, r,1,0,(r == 11),0);
    add(1,0,0,1,1, 0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0,0);
    // synchronous reset at round 5
    add(1,1,0,1,0, 0,1,1,0,0);
    for (int r = 1; r <= 5; r++) add(1,0,0,1,0, r,1,0,0,0);
    add(0,0,0,1,0, 0,0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0,0);

    foreach (vq[i]) begin
      drive(vq[i].rstb, vq[i].start, vq[i].mode, vq[i].en, vq[i].abort);
      chk("round", i, int'(round_a), int'(vq[i].round));
      chk("busy",  i, int'(busy_a),  int'(vq[i].busy));
      chk("first", i, int'(first_a), int'(vq[i].first));
      chk("last",  i, int'(last_a),  int'(vq[i].last));
      chk("done",  i, int'(done_a),  int'(vq[i].done));
    end

    // 16-round instance, single-round mode B: first and last together at 15
    drive(0,0,0,0,0);
    chk("b_rst_round", 0, int'(round_b), 0);
    chk("b_rst_busy",  0, int'(busy_b), 0);
    drive(1,1,1,1,0);
    chk("b_round", 1, int'(round_b), 15);
    chk("b_busy",  1, int'(busy_b), 1);
    chk("b_first", 1, int'(first_b), 1);
    chk("b_last",  1, int'(last_b), 1);
    chk("b_done",  1, int'(done_b), 0);
    drive(1,0,0,1,0);
    chk("b_done",  2, int'(done_b), 1);
    chk("b_busy",  2, int'(busy_b), 0);
    chk("b_round", 2, int'(round_b), 0);
    chk("b_first", 2, int'(first_b), 0);
    chk("b_last",  2, int'(last_b), 0);
    // mode A on the same instance starts at 16-12 = 4
    drive(1,1,0,1,0);
    chk("b_done",  3, int'(done_b), 0);
    chk("b_round", 3, int'(round_b), 4);
    chk("b_first", 3, int'(first_b), 1);
    chk("b_last",  3, int'(last_b), 0);
    drive(1,0,0,1,0);
    chk("b_round", 4, int'(round_b), 5);
    chk("b_first", 4, int'(first_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
